alu_reg: RTL and testbench
==========================

Name: alu_reg

Overview:
- 8-bit registered arithmetic/logic unit with a 3-bit opcode.
- Computes add, subtract, bitwise AND, bitwise OR and bitwise NOT of operand a. Opcodes 5-7 are reserved and produce zero.
- Result and status flags are registered, so the block drops into a single-clock datapath with a valid-qualified, 1-cycle-latency interface.

Parameters:
- WIDTH, 8, operand and result width in bits. All behaviour below is stated for 8; it generalises to any WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode valid this cycle
- opcode  input  3  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out  output  WIDTH  registered result
- out_valid  output  1  out and flags hold a new result this cycle
- carry  output  1  registered carry-out (add) or no-borrow (sub)
- overflow  output  1  registered signed overflow (add/sub)
- zero  output  1  registered flag, set when out == 0
- negative  output  1  registered flag, equal to out[WIDTH-1]

Behaviour:
- Reset:
  - rst_n low asynchronously forces out=0, out_valid=0, carry=0, overflow=0, zero=1, negative=0.
  - Release is synchronous to the next clk edge.
  - A reset asserted mid-operation discards the in-flight result.
- Opcode map (unsigned, modulo 2^WIDTH):
  - 0 PLUS: out = a + b. carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = (a[msb]==b[msb]) && (out[msb]!=a[msb]).
  - 1 MINUS: out = a - b, computed as a + ~b + 1. carry = 1 when a >= b unsigned (no borrow). overflow = (a[msb]!=b[msb]) && (out[msb]!=a[msb]).
  - 2 AND: out = a & b. carry=0, overflow=0.
  - 3 OR: out = a | b. carry=0, overflow=0.
  - 4 NEGATE: out = ~a; b is ignored. carry=0, overflow=0.
  - 5, 6, 7 reserved: out = 0, carry=0, overflow=0, so zero=1.
- zero and negative are always derived from the registered out value for every opcode.
- Latency and handshake:
  - On a rising clk edge with in_valid=1: out and all flags load the result of the current inputs, and out_valid=1 in the following cycle.
  - On an edge with in_valid=0: out and flags hold their previous values, and out_valid=0.
  - Back-to-back in_valid gives one result per cycle, with no stalls or backpressure.
- Wrap-around:
  - Add overflow wraps, e.g. 0xFF+0x01 gives 0x00 with carry=1 and zero=1.
  - Sub underflow wraps, e.g. 0x00-0x01 gives 0xFF with carry=0 and negative=1.
- X/unknown opcode values are not required to be handled; only the 8 defined encodings are specified.
- No internal state other than the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out=0x00, out_valid=0, zero=1 immediately, without waiting for a clk edge.
- Arithmetic, one cycle after each in_valid pulse:
  - a=10, b=5, op=0 -> out=15, carry=0, zero=0, out_valid=1.
  - a=15, b=6, op=1 -> out=9, carry=1.
  - a=0xFF, b=0x01, op=0 -> out=0x00, carry=1, zero=1.
  - a=0x7F, b=0x01, op=0 -> out=0x80, overflow=1, negative=1.
- Logic:
  - a=10101010, b=11001100, op=2 -> out=10001000.
  - Same operands, op=3 -> out=11101110.
  - a=00001111, b=0, op=4 -> out=11110000, negative=1.
- Reserved opcodes: a=00001111, b=0, op=7 -> out=00000000, zero=1. Repeat for op=5 and op=6 with the same result.
- Handshake:
  - Drive 4 back-to-back valid ops -> 4 consecutive out_valid cycles with the matching results in order.
  - Then in_valid=0 with changing a, b -> out_valid=0 and out holds the last result.
- Subtract boundary: a=0x00, b=0x01, op=1 -> out=0xFF, carry=0, negative=1. Then a=0x80, b=0x01, op=1 -> out=0x7F, overflow=1.

Source files
------------

// File: rtl/alu_reg.sv
// 8-bit (parameterisable) registered ALU with valid-qualified, 1-cycle-latency output.
// zero/negative are decoded from the registered result so they always agree with out.
module alu_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   typedef enum logic [2:0] {
      OP_PLUS   = 3'd0,
      OP_MINUS  = 3'd1,
      OP_AND    = 3'd2,
      OP_OR     = 3'd3,
      OP_NEGATE = 3'd4
   } op_e;

   logic [WIDTH-1:0] res_q, res_d;
   logic             valid_q;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] addend;
   logic             cin;
   logic [WIDTH:0]   sum_ext;

   // Subtract reuses the adder as a + ~b + 1, so carry-out is the no-borrow flag.
   always_comb begin
      addend  = (opcode == OP_MINUS) ? ~b : b;
      cin     = (opcode == OP_MINUS);
      sum_ext = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
   end

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (opcode)
         OP_PLUS, OP_MINUS: begin
            res_d   = sum_ext[WIDTH-1:0];
            carry_d = sum_ext[WIDTH];
            // Same-sign operands into the adder yielding a different sign covers add and sub alike.
            ovf_d   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:    res_d = a & b;
         OP_OR:     res_d = a | b;
         OP_NEGATE: res_d = ~a;
         default:   res_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign out       = res_q;
   assign out_valid = valid_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign zero      = (res_q == '0);
   assign negative  = res_q[WIDTH-1];

endmodule

// File: tb/tb_alu_reg.sv
// Scoreboard bench for alu_reg: directed vectors push expected results, a monitor pops on out_valid.
module tb_alu_reg;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] opcode;
   logic [7:0] a, b;
   logic [7:0] out;
   logic       out_valid, carry, overflow, zero, negative;

   typedef struct {
      logic [7:0] o;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic [7:0] last_out;

   alu_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out       (out),
      .out_valid (out_valid),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one valid operation in the next cycle and record its hand-computed result.
   task automatic issue(input logic [2:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] eo, input logic ec, input logic ev,
                        input logic ez, input logic en);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = op;
      a        = ia;
      b        = ib;
      e.o = eo; e.c = ec; e.v = ev; e.z = ez; e.n = en;
      sb.push_back(e);
      last_out = eo;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out"},       {24'd0, out}, 32'h00);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_carry"},     {31'd0, carry}, 32'd0);
      chk({tag, "_overflow"},  {31'd0, overflow}, 32'd0);
      chk({tag, "_zero"},      {31'd0, zero}, 32'd1);
      chk({tag, "_negative"},  {31'd0, negative}, 32'd0);
   endtask

   // Monitor: every presented result must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got out=%0h with no outstanding result", out);
            end else begin
               e = sb.pop_front();
               chk("out",      {24'd0, out}, {24'd0, e.o});
               chk("carry",    {31'd0, carry}, {31'd0, e.c});
               chk("overflow", {31'd0, overflow}, {31'd0, e.v});
               chk("zero",     {31'd0, zero}, {31'd0, e.z});
               chk("negative", {31'd0, negative}, {31'd0, e.n});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      opcode   = 3'd0;
      a        = 8'h00;
      b        = 8'h00;
      last_out = 8'h00;
      #1;
      chk_reset_vals("rst_init");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //      op    a      b      out    c     v     z     n
      issue(3'd0, 8'd10, 8'd5,  8'd15, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(3'd1, 8'd15, 8'd6,  8'd9,  1'b1, 1'b0, 1'b0, 1'b0);
      issue(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      issue(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset asserted mid-cycle discards an in-flight op and clears outputs without a clock edge.
      @(negedge clk);
      in_valid = 1'b1; opcode = 3'd0; a = 8'h11; b = 8'h22;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_async");
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_release");

      issue(3'd2, 8'b10101010, 8'b11001100, 8'b10001000, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(3'd3, 8'b10101010, 8'b11001100, 8'b11101110, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(3'd4, 8'b00001111, 8'h00,       8'b11110000, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(3'd7, 8'b00001111, 8'h00,       8'h00,       1'b0, 1'b0, 1'b1, 1'b0);
      issue(3'd5, 8'b00001111, 8'h00,       8'h00,       1'b0, 1'b0, 1'b1, 1'b0);
      issue(3'd6, 8'b00001111, 8'h00,       8'h00,       1'b0, 1'b0, 1'b1, 1'b0);
      issue(3'd4, 8'hFF,       8'h5A,       8'h00,       1'b0, 1'b0, 1'b1, 1'b0);
      issue(3'd1, 8'h00,       8'h01,       8'hFF,       1'b0, 1'b0, 1'b0, 1'b1);
      issue(3'd1, 8'h80,       8'h01,       8'h7F,       1'b1, 1'b1, 1'b0, 1'b0);
      issue(3'd1, 8'h5A,       8'h5A,       8'h00,       1'b1, 1'b0, 1'b1, 1'b0);
      issue(3'd0, 8'h80,       8'h80,       8'h00,       1'b1, 1'b1, 1'b1, 1'b0);
      issue(3'd1, 8'h7F,       8'hFF,       8'h80,       1'b0, 1'b1, 1'b0, 1'b1);

      // Four back-to-back ops, then idle cycles with changing operands: output must hold.
      issue(3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(3'd3, 8'h0F, 8'h80, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(3'd1, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
            chk("hold_out",       {24'd0, out}, {24'd0, last_out});
            chk("hold_carry",     {31'd0, carry}, 32'd1);
         end
         in_valid = 1'b0;
         opcode   = 3'($urandom_range(0, 7));
         a        = 8'($urandom);
         b        = 8'($urandom);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
